// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Writer side of the instruction-fetch path. A program image arrives as a byte
// stream framed as: 16-bit word count N, then N 16-bit data words, every field
// big-endian (high byte first). Each data word is written into the instruction
// memory at consecutive addresses starting from 0. The fetch unit is held
// disabled (cpu_en low) until the whole image has been written.
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN):
//   When defined, the data words are followed by a 16-bit checksum equal to the
//   sum of all data words mod 2^16 (0 when N == 0). A match ends in DONE, a
//   mismatch in ERR. Data words are still written as they arrive; only cpu_en
//   waits for the checksum to pass. When undefined there is no checksum field
//   and err is raised only for an oversize word count.
//
// Parameters:
//   ADDR_W     instruction memory address width, DEPTH = 2**ADDR_W words
//              (ADDR_W must be 16 or less)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, wins over every other input
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte
//   reload     single-cycle pulse, restarts loading from DONE or ERR
//   mem_we     instruction memory write strobe, one cycle per word
//   mem_addr   write address (holds its last value while mem_we is low)
//   mem_wdata  write data {hi, lo} (holds its last value while mem_we is low)
//   cpu_en     fetch unit enable, high only in DONE
//   done       image loaded successfully
//   err        frame error (oversize, or checksum mismatch when enabled)
//   dbg_state  current FSM state encoding, for observation only
//
// Handshake: a byte transfers on a rising clk edge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state (and rst), never on
// in_valid. The source may hold or drop in_valid at any time; the loader simply
// waits, so bytes may arrive with arbitrary gaps.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_en,
  output logic              done,
  output logic              err,
  output logic [3:0]        dbg_state
);

  // Word count limit; 17 bits so that 2**16 still fits for ADDR_W == 16.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  // S_SETTLE covers the cycle after the final byte of a frame: in the default
  // build the last mem_we pulse is still on the bus, with the checksum enabled
  // it is the cycle in which the received checksum is compared.
  typedef enum logic [3:0] {
    S_HDR_HI  = 4'd0,
    S_HDR_LO  = 4'd1,
    S_DAT_HI  = 4'd2,
    S_DAT_LO  = 4'd3,
    S_CSUM_HI = 4'd4,
    S_CSUM_LO = 4'd5,
    S_SETTLE  = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  state_t              state;
  state_t              state_n;

  logic [7:0]          hi_q;        // high byte of the field being received
  logic [ADDR_W-1:0]   word_idx;    // next write address, wraps after DEPTH-1
  logic [16:0]         words_left;  // data words still expected in this frame
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0]         sum_q;       // running sum of data words mod 2^16
  logic [15:0]         csum_q;      // checksum field as received
`endif

  logic                accept;
  logic [15:0]         field;       // {held high byte, current byte}
  logic                oversize;
  logic                last_word;
  logic                reload_ok;

  assign accept    = in_valid && in_ready;
  assign field     = {hi_q, in_data};
  assign oversize  = {1'b0, field} > DEPTH;
  assign last_word = (words_left == 17'd1);
  assign reload_ok = reload && ((state == S_DONE) || (state == S_ERR));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HDR_HI;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and ready
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;

    case (state)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (accept) state_n = S_HDR_LO;
      end

      S_HDR_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (oversize) begin
            state_n = S_ERR;
          end else if (field == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_n = S_CSUM_HI;
`else
            state_n = S_DONE;
`endif
          end else begin
            state_n = S_DAT_HI;
          end
        end
      end

      S_DAT_HI: begin
        in_ready = 1'b1;
        if (accept) state_n = S_DAT_LO;
      end

      S_DAT_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_n = S_CSUM_HI;
`else
            state_n = S_SETTLE;
`endif
          end else begin
            state_n = S_DAT_HI;
          end
        end
      end

      S_CSUM_HI: begin
        in_ready = 1'b1;
        if (accept) state_n = S_CSUM_LO;
      end

      S_CSUM_LO: begin
        in_ready = 1'b1;
        if (accept) state_n = S_SETTLE;
      end

      S_SETTLE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        state_n = (csum_q == sum_q) ? S_DONE : S_ERR;
`else
        state_n = S_DONE;
`endif
      end

      S_DONE, S_ERR: begin
        if (reload) state_n = S_HDR_HI;
      end

      default: begin
        state_n = S_HDR_HI;
      end
    endcase

    // Nothing is accepted in the reset cycle.
    if (rst) in_ready = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Datapath: field capture, word counting and the registered write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= 8'd0;
      word_idx   <= '0;
      words_left <= 17'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= 16'd0;
      csum_q     <= 16'd0;
`endif
    end else begin
      // The write strobe is a single-cycle pulse per completed word.
      we_q <= 1'b0;

      if (accept) begin
        case (state)
          S_HDR_HI, S_DAT_HI, S_CSUM_HI: begin
            hi_q <= in_data;
          end

          S_HDR_LO: begin
            words_left <= {1'b0, field};
            word_idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= 16'd0;
`endif
          end

          S_DAT_LO: begin
            we_q       <= 1'b1;
            addr_q     <= word_idx;
            wdata_q    <= field;
            word_idx   <= word_idx + 1'b1;
            words_left <= words_left - 17'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + field;
`endif
          end

`ifdef PROG_LOADER_CHECKSUM_EN
          S_CSUM_LO: begin
            csum_q <= field;
          end
`endif

          default: begin
          end
        endcase
      end

      if (reload_ok) begin
        word_idx   <= '0;
        words_left <= 17'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Gating with rst keeps every strobe low in the reset cycle, which
  // also drops a write that was pending when rst arrived.
  // ---------------------------------------------------------------------------
  assign mem_we    = we_q && !rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state == S_DONE) && !rst;
  assign cpu_en    = done;
  assign err       = (state == S_ERR) && !rst;
  assign dbg_state = state;

endmodule
